// File: rtl/image_pingpong_ctrl_if.sv
// Bundle of the DMA stream, BRAM write/read ports and layer-0 pixel stream
// that surround the ping-pong image bank controller.
interface image_pingpong_ctrl_if #(
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 10
);
  logic              enable;

  logic [PIX_W-1:0]  x_tdata;
  logic              x_tvalid;
  logic              x_tready;

  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;

  logic              rd_en;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;

  logic [PIX_W-1:0]  px_tdata;
  logic              px_tvalid;
  logic              px_tlast;
  logic              px_tready;

  logic [1:0]        bank_full;
  logic              frame_done;
  logic [15:0]       frame_cnt;

  // Controller side: accepts the DMA stream, drives both BRAM ports and layer 0.
  modport master (
    input  enable, x_tdata, x_tvalid, rd_data, px_tready,
    output x_tready, wr_en, wr_bank, wr_addr, wr_data,
           rd_en, rd_bank, rd_addr,
           px_tdata, px_tvalid, px_tlast,
           bank_full, frame_done, frame_cnt
  );

  // Environment side: DMA source, BRAM banks and layer-0 consumer.
  modport slave (
    output enable, x_tdata, x_tvalid, rd_data, px_tready,
    input  x_tready, wr_en, wr_bank, wr_addr, wr_data,
           rd_en, rd_bank, rd_addr,
           px_tdata, px_tvalid, px_tlast,
           bank_full, frame_done, frame_cnt
  );
endinterface

// File: rtl/image_pingpong_ctrl.sv
// Ping-pong scheduler for the two input-image BRAM banks feeding layer 0.
// One bank is filled from the DMA stream while the other is read out through
// a small output FIFO as a pixel stream; banks swap roles at frame boundaries.
module image_pingpong_ctrl #(
  parameter int PIX_W  = 12,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input logic                   clk,
  input logic                   rst,
  image_pingpong_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // The read pointer needs one extra bit so it can sit at DEPTH once the
  // whole frame has been requested, even when DEPTH == 2**ADDR_W.
  localparam int                PTR_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  END_PTR   = PTR_W'(DEPTH);
  localparam logic [3:0]        FIFO_SLOTS = 4'd4;

  // Bank arbitration state
  bank_state_t       bank_state      [2];
  bank_state_t       bank_state_next [2];
  logic              fill_bank;
  logic              fill_bank_next;
  logic              drain_bank;
  logic              drain_bank_next;
  logic [ADDR_W-1:0] fill_ptr;
  logic [ADDR_W-1:0] fill_ptr_next;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_next;

  // Registered BRAM write request
  logic              wr_pend;
  logic              wr_pend_bank;
  logic [ADDR_W-1:0] wr_pend_addr;
  logic [PIX_W-1:0]  wr_pend_data;

  // Read return tracking and output FIFO ({tlast, data} per entry)
  logic              inflight;
  logic              inflight_last;
  logic [PIX_W:0]    fifo_mem [4];
  logic [1:0]        fifo_head;
  logic [1:0]        fifo_tail;
  logic [2:0]        fifo_count;
  logic [3:0]        occupancy;

  // Frame accounting
  logic              frame_done_q;
  logic [15:0]       frame_cnt_q;

  // Per-cycle events
  logic              fill_open;
  logic              fill_ready;
  logic              beat;
  logic              drain_open;
  logic              read_go;
  logic              fifo_push;
  logic              fifo_pop;
  logic              last_pop;

  // Handshake and event decode, all derived from registered state so the
  // DMA and layer-0 sides never see a combinational path through each other.
  always_comb begin
    fill_open  = (bank_state[fill_bank] == EMPTY) || (bank_state[fill_bank] == FILLING);
    fill_ready = !rst && bus.enable && fill_open;
    beat       = bus.x_tvalid && fill_ready;

    drain_open = (bank_state[drain_bank] == FULL) || (bank_state[drain_bank] == DRAINING);
    occupancy  = {1'b0, fifo_count} + {3'b000, inflight};
    read_go    = !rst && bus.enable && drain_open && (rd_ptr < END_PTR) &&
                 (occupancy < FIFO_SLOTS);

    fifo_push  = inflight;
    fifo_pop   = (fifo_count != 3'd0) && bus.px_tready;
    last_pop   = fifo_pop && fifo_mem[fifo_head][PIX_W];
  end

  // Next-state logic for the two banks and both frame pointers. Fill completion
  // and drain completion always target different banks, so both may land on
  // the same edge without interfering.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_state_next[b] = bank_state[b];
    end
    fill_bank_next  = fill_bank;
    drain_bank_next = drain_bank;
    fill_ptr_next   = fill_ptr;
    rd_ptr_next     = rd_ptr;

    if (beat) begin
      if (fill_ptr == LAST_ADDR) begin
        bank_state_next[fill_bank] = FULL;
        fill_bank_next             = !fill_bank;
        fill_ptr_next              = '0;
      end else begin
        bank_state_next[fill_bank] = FILLING;
        fill_ptr_next              = fill_ptr + 1'b1;
      end
    end

    if (read_go) begin
      rd_ptr_next = rd_ptr + 1'b1;
      if (bank_state[drain_bank] == FULL) begin
        bank_state_next[drain_bank] = DRAINING;
      end
    end

    if (last_pop) begin
      bank_state_next[drain_bank] = EMPTY;
      drain_bank_next             = !drain_bank;
      rd_ptr_next                 = '0;
    end
  end

  // Bank state and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      fill_bank     <= 1'b0;
      drain_bank    <= 1'b0;
      fill_ptr      <= '0;
      rd_ptr        <= '0;
    end else begin
      bank_state[0] <= bank_state_next[0];
      bank_state[1] <= bank_state_next[1];
      fill_bank     <= fill_bank_next;
      drain_bank    <= drain_bank_next;
      fill_ptr      <= fill_ptr_next;
      rd_ptr        <= rd_ptr_next;
    end
  end

  // Accepted DMA beats are written into the fill bank one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend      <= 1'b0;
      wr_pend_bank <= 1'b0;
      wr_pend_addr <= '0;
      wr_pend_data <= '0;
    end else begin
      wr_pend <= beat;
      if (beat) begin
        wr_pend_bank <= fill_bank;
        wr_pend_addr <= fill_ptr;
        wr_pend_data <= bus.x_tdata;
      end
    end
  end

  // Remember which cycle's read returns data this cycle, and whether it was
  // the final word of the frame, so the FIFO entry can carry tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= read_go;
      inflight_last <= read_go && (rd_ptr == LAST_PTR);
    end
  end

  // Output FIFO: read data lands here and is presented to layer 0. The read
  // issue rule keeps count plus in-flight at or below four, so it never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= '0;
      end
      fifo_head  <= '0;
      fifo_tail  <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[fifo_tail] <= {inflight_last, bus.rd_data};
        fifo_tail           <= fifo_tail + 1'b1;
      end
      if (fifo_pop) begin
        fifo_head <= fifo_head + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame completion pulse and running count of drained frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= last_pop;
      if (last_pop) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Output drive. Strobes are masked by reset so a write or read captured just
  // before reset never reaches the BRAM while reset is held.
  always_comb begin
    bus.x_tready   = fill_ready;

    bus.wr_en      = wr_pend && !rst;
    bus.wr_bank    = wr_pend_bank;
    bus.wr_addr    = wr_pend_addr;
    bus.wr_data    = wr_pend_data;

    bus.rd_en      = read_go;
    bus.rd_bank    = drain_bank;
    bus.rd_addr    = rd_ptr[ADDR_W-1:0];

    bus.px_tvalid  = (fifo_count != 3'd0);
    bus.px_tdata   = fifo_mem[fifo_head][PIX_W-1:0];
    bus.px_tlast   = (fifo_count != 3'd0) && fifo_mem[fifo_head][PIX_W];

    bus.bank_full  = {bank_state[1] == FULL, bank_state[0] == FULL};
    bus.frame_done = frame_done_q;
    bus.frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_image_pingpong_ctrl.sv
// Self-checking bench for image_pingpong_ctrl: random DMA and layer-0 traffic
// against a frame-level reference model plus a behavioural dual-bank BRAM.
module tb_image_pingpong_ctrl;
  localparam int PIX_W  = 12;
  localparam int DEPTH  = 784;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  image_pingpong_ctrl_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  image_pingpong_ctrl #(.PIX_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state, all counted since the last reset
  logic [PIX_W-1:0] acc [$];
  int               beats;
  int               reads;
  int               landed;
  int               popped;
  bit               prev_beat;
  int               prev_beat_idx;
  logic [PIX_W-1:0] prev_beat_data;
  bit               prev_stall;
  logic [PIX_W-1:0] prev_px_data;
  bit               prev_last_pop;

  // Dual-bank BRAM with one-cycle read latency
  logic [PIX_W-1:0] bram [2][1 << ADDR_W];
  always @(posedge clk) begin
    if (bus.wr_en) bram[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
    if (bus.rd_en) bus.rd_data <= bram[bus.rd_bank][bus.rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Mid-cycle monitor: compares the DUT against the frame-level model, then
  // advances the model with the transfers that complete at the next edge.
  always @(negedge clk) begin
    int filled;
    int drained;
    int limit;
    int started;
    int exp_full;
    int exp_rd;
    if (rst) begin
      checkOutput("rst_x_tready", 32'(bus.x_tready), 0);
      checkOutput("rst_wr_en", 32'(bus.wr_en), 0);
      checkOutput("rst_rd_en", 32'(bus.rd_en), 0);
      acc.delete();
      beats = 0; reads = 0; landed = 0; popped = 0;
      prev_beat = 0; prev_stall = 0; prev_last_pop = 0;
    end else begin
      filled  = beats / DEPTH;
      drained = popped / DEPTH;

      checkOutput("x_tready", 32'(bus.x_tready),
                  (bus.enable && (filled - drained) < 2) ? 1 : 0);

      checkOutput("wr_en", 32'(bus.wr_en), prev_beat ? 1 : 0);
      if (prev_beat) begin
        checkOutput("wr_bank", 32'(bus.wr_bank), (prev_beat_idx / DEPTH) % 2);
        checkOutput("wr_addr", 32'(bus.wr_addr), prev_beat_idx % DEPTH);
        checkOutput("wr_data", 32'(bus.wr_data), 32'(prev_beat_data));
      end

      limit  = ((filled < drained + 1) ? filled : drained + 1) * DEPTH;
      exp_rd = (bus.enable && reads < limit && (reads - popped) < 4) ? 1 : 0;
      checkOutput("rd_en", 32'(bus.rd_en), exp_rd);
      if (bus.rd_en) begin
        checkOutput("rd_bank", 32'(bus.rd_bank), (reads / DEPTH) % 2);
        checkOutput("rd_addr", 32'(bus.rd_addr), reads % DEPTH);
      end
      checkOutput("outstanding_le4", (reads - popped <= 4) ? 1 : 0, 1);

      checkOutput("px_tvalid", 32'(bus.px_tvalid), (landed > popped) ? 1 : 0);
      if (bus.px_tvalid && acc.size() > 0) begin
        checkOutput("px_tdata", 32'(bus.px_tdata), 32'(acc[0]));
        checkOutput("px_tlast", 32'(bus.px_tlast), (popped % DEPTH == DEPTH - 1) ? 1 : 0);
      end
      if (prev_stall) begin
        checkOutput("px_hold_valid", 32'(bus.px_tvalid), 1);
        checkOutput("px_hold_data", 32'(bus.px_tdata), 32'(prev_px_data));
      end

      checkOutput("frame_done", 32'(bus.frame_done), prev_last_pop ? 1 : 0);
      checkOutput("frame_cnt", 32'(bus.frame_cnt), drained % 65536);

      started  = (reads + DEPTH - 1) / DEPTH;
      exp_full = 0;
      for (int i = started; i < filled; i++) exp_full = exp_full | (1 << (i % 2));
      checkOutput("bank_full", 32'(bus.bank_full), exp_full);

      prev_beat = bus.x_tvalid && bus.x_tready;
      if (prev_beat) begin
        prev_beat_idx  = beats;
        prev_beat_data = bus.x_tdata;
        acc.push_back(bus.x_tdata);
        beats++;
      end
      landed = reads;
      if (bus.rd_en) reads++;
      prev_last_pop = 0;
      if (bus.px_tvalid && bus.px_tready) begin
        prev_last_pop = (popped % DEPTH == DEPTH - 1);
        if (acc.size() > 0) void'(acc.pop_front());
        popped++;
      end
      prev_stall   = bus.px_tvalid && !bus.px_tready;
      prev_px_data = bus.px_tdata;
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_x_tready"},   32'(bus.x_tready), 0);
    checkOutput({tag, "_wr_en"},      32'(bus.wr_en), 0);
    checkOutput({tag, "_wr_bank"},    32'(bus.wr_bank), 0);
    checkOutput({tag, "_wr_addr"},    32'(bus.wr_addr), 0);
    checkOutput({tag, "_wr_data"},    32'(bus.wr_data), 0);
    checkOutput({tag, "_rd_en"},      32'(bus.rd_en), 0);
    checkOutput({tag, "_rd_bank"},    32'(bus.rd_bank), 0);
    checkOutput({tag, "_rd_addr"},    32'(bus.rd_addr), 0);
    checkOutput({tag, "_px_tvalid"},  32'(bus.px_tvalid), 0);
    checkOutput({tag, "_px_tdata"},   32'(bus.px_tdata), 0);
    checkOutput({tag, "_px_tlast"},   32'(bus.px_tlast), 0);
    checkOutput({tag, "_bank_full"},  32'(bus.bank_full), 0);
    checkOutput({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    checkOutput({tag, "_frame_cnt"},  32'(bus.frame_cnt), 0);
  endtask

  // Holds reset for two edges with enable high, checking the reset state after the first.
  task automatic resetDut(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.enable    = 1'b1;
    bus.x_tvalid  = 1'b0;
    bus.px_tready = 1'b0;
    @(posedge clk); #1;
    checkResetState(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Random traffic until drain_target frames are drained (or for max_cycles
  // when drain_target < 0). Optional one-shot 10-cycle enable drops when the
  // fill or drain position within a frame reaches the given index.
  task automatic applyStimulus(input int valid_pct, input int ready_pct,
                               input int beat_limit, input int drain_target,
                               input int fill_pause_at, input int drain_pause_at,
                               input int max_cycles);
    int n = 0;
    int pause_left = 0;
    bit fill_paused = 0;
    bit drain_paused = 0;
    while ((drain_target < 0 || popped / DEPTH < drain_target) && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
      if (!fill_paused && fill_pause_at >= 0 && beats < beat_limit &&
          beats % DEPTH == fill_pause_at) begin
        fill_paused = 1;
        pause_left  = 10;
      end
      if (!drain_paused && drain_pause_at >= 0 && popped % DEPTH == drain_pause_at &&
          reads > popped) begin
        drain_paused = 1;
        pause_left   = 10;
      end
      if (pause_left > 0) begin
        pause_left--;
        bus.enable = 1'b0;
      end else begin
        bus.enable = 1'b1;
      end
      bus.x_tvalid  = (beats < beat_limit) && ($urandom_range(99) < valid_pct);
      bus.x_tdata   = PIX_W'($urandom);
      bus.px_tready = ($urandom_range(99) < ready_pct);
    end
    if (drain_target >= 0) checkOutput("run_done", (popped / DEPTH >= drain_target) ? 1 : 0, 1);
    bus.x_tvalid = 1'b0;
  endtask

  initial begin
    int n;
    int gap;
    bus.enable    = 1'b0;
    bus.x_tvalid  = 1'b0;
    bus.x_tdata   = '0;
    bus.px_tready = 1'b0;

    // One full frame with free-flowing handshakes
    resetDut("reset1");
    applyStimulus(100, 100, DEPTH, 1, -1, -1, 4000);
    checkOutput("t1_frame_cnt", 32'(bus.frame_cnt), 1);
    checkOutput("t1_frame_done", 32'(bus.frame_done), 1);
    checkOutput("t1_bank_full", 32'(bus.bank_full), 0);

    // Back-pressure from layer 0: fill stalls after two frames, then a third lands
    resetDut("reset2");
    applyStimulus(100, 0, 3 * DEPTH, -1, -1, -1, 2 * DEPTH + 50);
    checkOutput("t2_beats_stalled", beats, 2 * DEPTH);
    checkOutput("t2_x_tready_low", 32'(bus.x_tready), 0);
    applyStimulus(100, 100, 3 * DEPTH, 3, -1, -1, 6000);
    checkOutput("t2_frame_cnt", 32'(bus.frame_cnt), 3);

    // Fill of bank 1 timed to complete on the same edge as the bank 0 drain
    resetDut("reset3");
    bus.px_tready = 1'b1;
    n = 0;
    gap = 0;
    while (popped < DEPTH && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (beats == DEPTH && gap < 2) begin
        bus.x_tvalid = 1'b0;
        gap++;
      end else begin
        bus.x_tvalid = (beats < 2 * DEPTH);
      end
      bus.x_tdata = PIX_W'($urandom);
    end
    checkOutput("t5_beats", beats, 2 * DEPTH);
    checkOutput("t5_bank_full", 32'(bus.bank_full), 2);
    checkOutput("t5_x_tready", 32'(bus.x_tready), 1);
    checkOutput("t5_frame_cnt", 32'(bus.frame_cnt), 1);
    applyStimulus(100, 100, 2 * DEPTH, 2, -1, -1, 3000);

    // Random back-pressure on both streams
    resetDut("reset4");
    applyStimulus(70, 50, 3 * DEPTH, 3, -1, -1, 20000);

    // enable drops at fill beat 400 and drain word 200
    resetDut("reset5");
    applyStimulus(100, 100, 2 * DEPTH, 2, 400, 200, 6000);
    checkOutput("t4_frame_cnt", 32'(bus.frame_cnt), 2);

    // Reset mid-operation while bank 1 fills and bank 0 drains, then a fresh frame
    resetDut("reset6");
    applyStimulus(100, 100, DEPTH + 300, -1, -1, -1, DEPTH + 305);
    checkOutput("t6_beats", beats, DEPTH + 300);
    checkOutput("t6_drain_active", 32'(bus.px_tvalid), 1);
    rst = 1'b1;
    bus.x_tvalid = 1'b1;
    @(posedge clk); #1;
    checkResetState("t6");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.x_tvalid = 1'b0;
    applyStimulus(100, 100, DEPTH, 1, -1, -1, 4000);
    checkOutput("t6_frame_cnt", 32'(bus.frame_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
